clock_factor_meter: RTL and testbench

Measures the period of a slow, asynchronous square wave in cycles of the fast clock, recovering the division factor that produced it. Typical source is a divided clock output; the result drives display and self-check logic. The block contains an input synchronizer, a rising-edge detector, a period counter, a lock qualifier and a timeout monitor.

---
 rtl/clock_factor_meter.sv | 87 ++++++++
 tb/tb_clock_factor_meter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/clock_factor_meter.sv
// clock_factor_meter: measures the period of an asynchronous square wave in ClkIn cycles.
// Defining DUTY_MEASURE_EN adds HighTime, the high-phase length latched with each Factor.
module clock_factor_meter #(
    parameter int WIDTH = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             ClkIn,
    input  logic             reset,
    input  logic             Enable,
    input  logic             SigIn,
`ifdef DUTY_MEASURE_EN
    output logic [WIDTH-1:0] HighTime,
`endif
    output logic [WIDTH-1:0] Factor,
    output logic             Valid,
    output logic             Locked,
    output logic             Timeout
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    state_t state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic [WIDTH-1:0] count;
    logic hist, rise, primed, take, expire, same_high;
    assign rise = sync[SYNC_STAGES-1] & ~hist;
    always_comb begin
        state_next = state;
        take = 1'b0;
        expire = 1'b0;
        if (!Enable) state_next = IDLE;
        else case (state)
            IDLE: state_next = ARM;
            ARM: state_next = rise ? MEASURE : ARM;
            default: begin
                take = rise;
                expire = !rise && count == ALL_ONES;
                state_next = expire ? ARM : MEASURE;
            end
        endcase
    end
    always_ff @(posedge ClkIn or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sync <= '0;
            hist <= 1'b0;
            count <= '0;
            primed <= 1'b0;
            Factor <= '0;
            Valid <= 1'b0;
            Locked <= 1'b0;
            Timeout <= 1'b0;
        end else begin
            state <= state_next;
            sync <= {sync[SYNC_STAGES-2:0], SigIn};
            hist <= sync[SYNC_STAGES-1];
            Valid <= take;
            // primed marks that a Valid has already been produced since the last ARM
            primed <= state_next == MEASURE && (primed || take);
            if (rise && state_next == MEASURE) count <= WIDTH'(1);
            else if (count != ALL_ONES) count <= count + WIDTH'(1);
            if (take) begin
                Factor <= count;
                Locked <= primed && count == Factor && same_high;
                Timeout <= 1'b0;
            end else begin
                if (state_next != MEASURE) Locked <= 1'b0;
                if (expire) Timeout <= 1'b1;
            end
        end
    end
`ifdef DUTY_MEASURE_EN
    logic [WIDTH-1:0] high_cnt;
    assign same_high = high_cnt == HighTime;
    always_ff @(posedge ClkIn or negedge reset) begin
        if (!reset) begin
            high_cnt <= '0;
            HighTime <= '0;
        end else begin
            if (rise) high_cnt <= WIDTH'(1);
            else if (sync[SYNC_STAGES-1] && high_cnt != ALL_ONES) high_cnt <= high_cnt + WIDTH'(1);
            if (take) HighTime <= high_cnt;
        end
    end
`else
    assign same_high = 1'b1;
`endif
endmodule

// File: tb/tb_clock_factor_meter.sv
// tb_clock_factor_meter: randomized and directed stimulus checked against a timestamp-based reference model.
module tb_clock_factor_meter;
    localparam int W = 8;
    localparam int S = 2;
    localparam int MAXC = (1 << W) - 1;
    logic clk = 1'b0, reset = 1'b0, en = 1'b0, sig = 1'b0;
    logic [W-1:0] factor;
    logic valid, locked, timeout;
`ifdef DUTY_MEASURE_EN
    logic [W-1:0] high_time;
`endif
    clock_factor_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .ClkIn(clk), .reset(reset), .Enable(en), .SigIn(sig),
`ifdef DUTY_MEASURE_EN
        .HighTime(high_time),
`endif
        .Factor(factor), .Valid(valid), .Locked(locked), .Timeout(timeout)
    );
    always #5 clk = ~clk;
    int compared = 0, mismatched = 0;
    int mode = 0, cyc = 0, t0 = 0, m_factor = 0, primed = 0, hi = 0, m_high = 0, ph = 0;
    logic m_valid = 1'b0, m_locked = 1'b0, m_timeout = 1'b0;
    logic sq[$];
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask
    task automatic check_all();
        check("factor", 32'(factor), 32'(m_factor));
        check("valid", 32'(valid), 32'(m_valid));
        check("locked", 32'(locked), 32'(m_locked));
        check("timeout", 32'(timeout), 32'(m_timeout));
`ifdef DUTY_MEASURE_EN
        check("high_time", 32'(high_time), 32'(m_high));
`endif
    endtask
    task automatic model_reset();
        mode = 0; primed = 0; hi = 0; m_high = 0; m_factor = 0;
        m_valid = 0; m_locked = 0; m_timeout = 0;
        sq.delete();
        repeat (S + 1) sq.push_back(1'b0);
    endtask
    // sq[0] is the sample taken at the previous edge; sq[S-1] is what the synchronizer presents now
    task automatic step(logic s, logic e);
        logic r;
        int f;
        sig = s; en = e;
        @(posedge clk);
        cyc++;
        if (!reset) model_reset();
        else begin
            r = sq[S-1] & ~sq[S];
            m_valid = 0;
            if (!e) begin mode = 0; m_locked = 0; end
            else if (mode == 0) mode = 1;
            else if (mode == 1) begin
                if (r) begin mode = 2; t0 = cyc; primed = 0; end
            end else if (r) begin
                f = cyc - t0;
                m_locked = primed == 1 && f == m_factor
`ifdef DUTY_MEASURE_EN
                    && hi == m_high
`endif
                    ;
                m_factor = f; m_high = hi; primed = 1;
                m_timeout = 0; m_valid = 1; t0 = cyc;
            end else if (cyc - t0 >= MAXC) begin
                m_timeout = 1; m_locked = 0; mode = 1;
            end
            hi = r ? 1 : (hi + int'(sq[S-1]) > MAXC ? MAXC : hi + int'(sq[S-1]));
            sq.push_front(s);
            void'(sq.pop_back());
        end
        #1 check_all();
    endtask
    task automatic wave(int h, int l, int n, logic e);
        ph = ph % (h + l);
        for (int i = 0; i < n; i++) begin
            step(ph < h, e);
            ph = (ph + 1) % (h + l);
        end
    endtask
    initial begin
        int h, l;
        model_reset();
        #1 check_all();
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        reset = 1'b1;
        wave(5, 5, 75, 1'b1);
        check("lock_p10", 32'(locked), 1);
        check("factor_p10", 32'(factor), 10);
        wave(12, 12, 100, 1'b1);
        check("lock_p24", 32'(locked), 1);
        check("factor_p24", 32'(factor), 24);
        repeat (6) begin
            h = $urandom_range(1, 12);
            l = $urandom_range(1, 12);
            wave(h, l, (h + l) * 6, 1'b1);
            check("factor_rand", 32'(factor), 32'(h + l));
            check("lock_rand", 32'(locked), 1);
        end
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (300) step(1'b0, 1'b1);
        check("timeout_set", 32'(timeout), 1);
        check("timeout_unlock", 32'(locked), 0);
        ph = 0;
        wave(5, 5, 40, 1'b1);
        check("timeout_clear", 32'(timeout), 0);
        check("factor_restore", 32'(factor), 10);
        ph = 0;
        wave(1, 254, 255 * 3, 1'b1);
        check("factor_max", 32'(factor), MAXC);
        check("no_timeout_max", 32'(timeout), 0);
        ph = 0;
        wave(1, 255, 256 * 2, 1'b1);
        check("timeout_256", 32'(timeout), 1);
        ph = 0;
        wave(5, 5, 40, 1'b1);
        wave(5, 5, 4, 1'b1);
        wave(5, 5, 20, 1'b0);
        check("factor_hold", 32'(factor), 10);
        wave(5, 5, 40, 1'b1);
        check("factor_reenable", 32'(factor), 10);
        wave(5, 5, 13, 1'b1);
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        step(sig, 1'b1);
        #1 reset = 1'b1;
        wave(5, 5, 40, 1'b1);
        check("factor_after_reset", 32'(factor), 10);
        ph = 0;
        wave(3, 7, 60, 1'b1);
        check("factor_duty", 32'(factor), 10);
        check("lock_duty", 32'(locked), 1);
`ifdef DUTY_MEASURE_EN
        check("high_duty", 32'(high_time), 3);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
